// File: rtl/fm0_decode_seq.sv
// fm0_decode_seq: frame sequencer for the FM0 Viterbi decoder chain.
// Resets the chain per window, gates TB symbols in, and stitches the traceback results into a frame.
module fm0_decode_seq #(
    parameter int TB       = 5,
    parameter int MAX_WIN  = 4,
    parameter int TIMEOUT  = 255,
    localparam int NW      = $clog2(MAX_WIN + 1),
    localparam int SW      = $clog2(TB + 1),
    localparam int TW      = $clog2(TIMEOUT + 1),
    localparam int FW      = MAX_WIN * TB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] n_win,
    input  logic          corr_vld,
    output logic          dec_vld,
    output logic          dec_rst,
    input  logic [TB-1:0] tb_dat,
    input  logic          tb_vld,
    output logic [FW-1:0] frame_dat,
    output logic          frame_vld,
    output logic          frame_err,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        COLLECT,
        WAIT_TB,
        DONE
    } state_t;

    state_t        state;
    logic [NW-1:0] n_lat;
    logic [NW-1:0] win_cnt;
    logic [NW-1:0] win_nxt;
    logic [SW-1:0] sym_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          overrun;
    logic          err;
    logic          bad_len;
    logic          tmo_hit;

    assign win_nxt = win_cnt + 1'b1;
    assign bad_len = (n_win == '0) || (n_win > NW'(MAX_WIN));
    // The cycle that brings the idle count up to TIMEOUT is the last one.
    assign tmo_hit = (tmo_cnt >= TW'(TIMEOUT - 1));

    // Symbols reach the decoder only while a window is being collected.
    assign dec_vld = (state == COLLECT) && corr_vld;
    assign busy    = (state != IDLE);

    // Frame sequencing FSM; strobes default low and pulse for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n_lat     <= '0;
            win_cnt   <= '0;
            sym_cnt   <= '0;
            tmo_cnt   <= '0;
            overrun   <= 1'b0;
            err       <= 1'b0;
            dec_rst   <= 1'b0;
            frame_vld <= 1'b0;
            frame_err <= 1'b0;
            frame_dat <= '0;
        end else begin
            dec_rst   <= 1'b0;
            frame_vld <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        overrun <= 1'b0;
                        if (bad_len) begin
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            err       <= 1'b0;
                            n_lat     <= n_win;
                            win_cnt   <= '0;
                            frame_dat <= '0;
                            dec_rst   <= 1'b1;
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (corr_vld) overrun <= 1'b1;
                    sym_cnt <= '0;
                    tmo_cnt <= '0;
                    state   <= COLLECT;
                end
                COLLECT: begin
                    if (corr_vld) begin
                        sym_cnt <= sym_cnt + 1'b1;
                        tmo_cnt <= '0;
                        if (sym_cnt == SW'(TB - 1)) state <= WAIT_TB;
                    end else if (tmo_hit) begin
                        tmo_cnt <= TW'(TIMEOUT);
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                WAIT_TB: begin
                    if (corr_vld) overrun <= 1'b1;
                    if (tb_vld) begin
                        frame_dat <= (frame_dat << TB) | FW'(tb_dat);
                        win_cnt   <= win_nxt;
                        tmo_cnt   <= '0;
                        if (win_nxt == n_lat) begin
                            state <= DONE;
                        end else begin
                            dec_rst <= 1'b1;
                            state   <= FLUSH;
                        end
                    end else if (tmo_hit) begin
                        tmo_cnt <= TW'(TIMEOUT);
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (corr_vld) overrun <= 1'b1;
                    frame_vld <= 1'b1;
                    frame_err <= overrun | corr_vld | err;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
